// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: bundles the two cache-side request ports and the shared
// SRAM-like master port that the arbiter sits between.
//
// Handshake semantics (single description for every signal in this bundle):
//   - A cache port raises req_i[n] with we/be/addr/wdata and holds them
//     stable until gnt_o[n] is seen high at a rising edge.
//   - Downstream, a request transfers on a rising edge where
//     sram_req && sram_addr_ok. Once sram_req is raised it is not withdrawn
//     and its payload does not change until that transfer.
//   - sram_data_ok marks one response per accepted request, in issue order;
//     the arbiter forwards it combinationally as rvalid_o[n] / rdata_o.
//
// Modports:
//   master - the arbiter's view (drives grants, responses, the SRAM request)
//   slave  - the environment's view (caches and SRAM model)
interface sram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [1:0]                   req_i;
  logic [1:0]                   we_i;
  logic [1:0][DATA_W/8-1:0]     be_i;
  logic [1:0][ADDR_W-1:0]       addr_i;
  logic [1:0][DATA_W-1:0]       wdata_i;
  logic [1:0]                   gnt_o;
  logic [1:0]                   rvalid_o;
  logic [DATA_W-1:0]            rdata_o;
  logic                         sram_req;
  logic                         sram_we;
  logic [DATA_W/8-1:0]          sram_be;
  logic [ADDR_W-1:0]            sram_addr;
  logic [DATA_W-1:0]            sram_wdata;
  logic                         sram_addr_ok;
  logic                         sram_data_ok;
  logic [DATA_W-1:0]            sram_rdata;
  logic                         resp_err;

  modport master (
    input  req_i, we_i, be_i, addr_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o,
    output sram_req, sram_we, sram_be, sram_addr, sram_wdata,
    input  sram_addr_ok, sram_data_ok, sram_rdata,
    output resp_err
  );

  modport slave (
    output req_i, we_i, be_i, addr_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o,
    input  sram_req, sram_we, sram_be, sram_addr, sram_wdata,
    output sram_addr_ok, sram_data_ok, sram_rdata,
    input  resp_err
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM-like master port between the dcache (port 0)
// and the icache (port 1). Round-robin between contending ports, holds a
// presented request until the address handshake, and routes in-order
// responses back through a small FIFO of issuing port IDs.
//
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - sram_arbiter_if.master (cache ports, SRAM port, resp_err)
module sram_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32
) (
  input  logic           clk,
  input  logic           rst,
  sram_arbiter_if.master bus
);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTSTANDING);

  logic          rr_ptr;
  logic          locked;
  logic          lock_id;
  logic          fifo_id [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          resp_err_q;

  logic                sel;
  logic                sel_valid;
  logic                req_out;
  logic                accept;
  logic                pop;
  logic                head;
  logic [ADDR_W-1:0]   addr_mux;
  logic [DATA_W-1:0]   wdata_mux;
  logic [DATA_W/8-1:0] be_mux;
  logic [DATA_W-1:0]   rdata_mux;

  // Once a request has been shown without addr_ok it is pinned to lock_id
  // so the payload on the bus cannot switch ports before the handshake.
  always_comb begin
    sel       = rr_ptr;
    sel_valid = 1'b0;
    if (locked) begin
      sel       = lock_id;
      sel_valid = 1'b1;
    end else begin
      case (bus.req_i)
        2'b01:   begin sel = 1'b0;   sel_valid = 1'b1; end
        2'b10:   begin sel = 1'b1;   sel_valid = 1'b1; end
        2'b11:   begin sel = rr_ptr; sel_valid = 1'b1; end
        default: begin sel = rr_ptr; sel_valid = 1'b0; end
      endcase
    end
  end

  // No full-bypass: a pop in the same cycle does not open a slot.
  assign req_out = sel_valid && (count < FULL_CNT);
  assign accept  = req_out && bus.sram_addr_ok;
  assign pop     = bus.sram_data_ok && (count != '0);
  assign head    = fifo_id[rd_ptr];

  always_comb begin
    addr_mux  = '0;
    wdata_mux = '0;
    be_mux    = '0;
    rdata_mux = '0;
    if (req_out) begin
      addr_mux  = bus.addr_i[sel];
      wdata_mux = bus.wdata_i[sel];
      be_mux    = bus.be_i[sel];
    end
    if (pop) rdata_mux = bus.sram_rdata;
  end

  assign bus.sram_req   = req_out;
  assign bus.sram_we    = req_out && bus.we_i[sel];
  assign bus.sram_be    = be_mux;
  assign bus.sram_addr  = addr_mux;
  assign bus.sram_wdata = wdata_mux;
  assign bus.gnt_o      = accept ? (sel ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rvalid_o   = pop ? (head ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rdata_o    = rdata_mux;
  assign bus.resp_err   = resp_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= 1'b0;
      locked     <= 1'b0;
      lock_id    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      resp_err_q <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_id[i] <= 1'b0;
    end else begin
      if (accept) begin
        fifo_id[wr_ptr] <= sel;
        wr_ptr          <= wr_ptr + 1'b1;
        rr_ptr          <= ~sel;
        locked          <= 1'b0;
      end else if (req_out) begin
        locked  <= 1'b1;
        lock_id <= sel;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A response with nothing outstanding is dropped and flagged.
      if (bus.sram_data_ok && (count == '0)) resp_err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  sram_arbiter #(
    .MAX_OUTSTANDING(4),
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req_i        = 2'b00;
    bus.we_i         = 2'b00;
    bus.be_i         = '0;
    bus.addr_i       = '0;
    bus.wdata_i      = '0;
    bus.sram_addr_ok = 1'b0;
    bus.sram_data_ok = 1'b0;
    bus.sram_rdata   = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    #1;
    chk("rst_sram_req", 64'(bus.sram_req), 64'h0);
    chk("rst_resp_err", 64'(bus.resp_err), 64'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    idle_inputs();

    // Reset state
    #2;
    chk("reset_sram_req", 64'(bus.sram_req), 64'h0);
    chk("reset_gnt", 64'(bus.gnt_o), 64'h0);
    chk("reset_rvalid", 64'(bus.rvalid_o), 64'h0);
    chk("reset_rdata", 64'(bus.rdata_o), 64'h0);
    chk("reset_resp_err", 64'(bus.resp_err), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Single port dcache read
    @(negedge clk);
    bus.req_i = 2'b01; bus.addr_i[0] = 32'h100; bus.sram_addr_ok = 1'b1;
    #1;
    chk("single_sram_req", 64'(bus.sram_req), 64'h1);
    chk("single_addr", 64'(bus.sram_addr), 64'h100);
    chk("single_we", 64'(bus.sram_we), 64'h0);
    chk("single_gnt", 64'(bus.gnt_o), 64'h1);
    @(negedge clk);
    bus.req_i = 2'b00; bus.sram_addr_ok = 1'b0;
    #1;
    chk("single_idle_req", 64'(bus.sram_req), 64'h0);
    chk("single_idle_rvalid", 64'(bus.rvalid_o), 64'h0);
    @(negedge clk);
    bus.sram_data_ok = 1'b1; bus.sram_rdata = 32'hDEADBEEF;
    #1;
    chk("single_rvalid", 64'(bus.rvalid_o), 64'h1);
    chk("single_rdata", 64'(bus.rdata_o), 64'hDEADBEEF);
    @(negedge clk);
    bus.sram_data_ok = 1'b0;
    #1;
    chk("single_done_rvalid", 64'(bus.rvalid_o), 64'h0);
    chk("single_no_err", 64'(bus.resp_err), 64'h0);

    // Contention: alternate grants, fill FIFO, full hold, pop, reassert, drain
    do_reset();
    @(negedge clk);
    bus.req_i = 2'b11; bus.addr_i[0] = 32'hA0; bus.addr_i[1] = 32'hB0;
    bus.sram_addr_ok = 1'b1;
    #1;
    chk("cont_gnt0", 64'(bus.gnt_o), 64'h1);
    chk("cont_addr0", 64'(bus.sram_addr), 64'hA0);
    @(negedge clk); #1;
    chk("cont_gnt1", 64'(bus.gnt_o), 64'h2);
    chk("cont_addr1", 64'(bus.sram_addr), 64'hB0);
    @(negedge clk); #1;
    chk("cont_gnt2", 64'(bus.gnt_o), 64'h1);
    @(negedge clk); #1;
    chk("cont_gnt3", 64'(bus.gnt_o), 64'h2);
    @(negedge clk);
    bus.sram_data_ok = 1'b1; bus.sram_rdata = 32'h11;
    #1;
    chk("full_sram_req", 64'(bus.sram_req), 64'h0);
    chk("full_gnt", 64'(bus.gnt_o), 64'h0);
    chk("full_pop_rvalid", 64'(bus.rvalid_o), 64'h1);
    chk("full_pop_rdata", 64'(bus.rdata_o), 64'h11);
    @(negedge clk);
    bus.sram_data_ok = 1'b0;
    #1;
    chk("full_reassert_req", 64'(bus.sram_req), 64'h1);
    chk("full_reassert_gnt", 64'(bus.gnt_o), 64'h1);
    chk("full_reassert_addr", 64'(bus.sram_addr), 64'hA0);
    @(negedge clk);
    bus.req_i = 2'b00; bus.sram_addr_ok = 1'b0;
    bus.sram_data_ok = 1'b1; bus.sram_rdata = 32'h21;
    #1;
    chk("drain0_req", 64'(bus.sram_req), 64'h0);
    chk("drain0_rvalid", 64'(bus.rvalid_o), 64'h2);
    chk("drain0_rdata", 64'(bus.rdata_o), 64'h21);
    @(negedge clk);
    bus.sram_rdata = 32'h22;
    #1;
    chk("drain1_rvalid", 64'(bus.rvalid_o), 64'h1);
    chk("drain1_rdata", 64'(bus.rdata_o), 64'h22);
    @(negedge clk);
    bus.sram_rdata = 32'h23;
    #1;
    chk("drain2_rvalid", 64'(bus.rvalid_o), 64'h2);
    @(negedge clk);
    bus.sram_rdata = 32'h24;
    #1;
    chk("drain3_rvalid", 64'(bus.rvalid_o), 64'h1);
    @(negedge clk);
    bus.sram_data_ok = 1'b0;
    #1;
    chk("drain_done_rvalid", 64'(bus.rvalid_o), 64'h0);
    chk("drain_no_err", 64'(bus.resp_err), 64'h0);

    // Lock: port 1 held without addr_ok while port 0 joins
    do_reset();
    @(negedge clk);
    bus.req_i = 2'b10; bus.we_i = 2'b10; bus.be_i[1] = 4'hC;
    bus.addr_i[1] = 32'h200; bus.wdata_i[1] = 32'h55AA;
    bus.addr_i[0] = 32'h300; bus.sram_addr_ok = 1'b0;
    #1;
    chk("lock_c1_req", 64'(bus.sram_req), 64'h1);
    chk("lock_c1_addr", 64'(bus.sram_addr), 64'h200);
    chk("lock_c1_we", 64'(bus.sram_we), 64'h1);
    chk("lock_c1_be", 64'(bus.sram_be), 64'hC);
    chk("lock_c1_wdata", 64'(bus.sram_wdata), 64'h55AA);
    chk("lock_c1_gnt", 64'(bus.gnt_o), 64'h0);
    @(negedge clk);
    bus.req_i = 2'b11;
    #1;
    chk("lock_c2_addr", 64'(bus.sram_addr), 64'h200);
    chk("lock_c2_gnt", 64'(bus.gnt_o), 64'h0);
    @(negedge clk); #1;
    chk("lock_c3_addr", 64'(bus.sram_addr), 64'h200);
    @(negedge clk);
    bus.sram_addr_ok = 1'b1;
    #1;
    chk("lock_gnt", 64'(bus.gnt_o), 64'h2);
    chk("lock_gnt_addr", 64'(bus.sram_addr), 64'h200);
    @(negedge clk); #1;
    chk("after_lock_gnt", 64'(bus.gnt_o), 64'h1);
    chk("after_lock_addr", 64'(bus.sram_addr), 64'h300);
    chk("after_lock_we", 64'(bus.sram_we), 64'h0);
    @(negedge clk);
    bus.req_i = 2'b00; bus.sram_addr_ok = 1'b0;
    #1;
    chk("idle_addr_zero", 64'(bus.sram_addr), 64'h0);
    chk("idle_be_zero", 64'(bus.sram_be), 64'h0);
    chk("idle_wdata_zero", 64'(bus.sram_wdata), 64'h0);

    // Error: reset with two in flight, then a stray response
    do_reset();
    @(negedge clk);
    bus.sram_data_ok = 1'b1; bus.sram_rdata = 32'h77;
    #1;
    chk("err_rvalid", 64'(bus.rvalid_o), 64'h0);
    chk("err_rdata", 64'(bus.rdata_o), 64'h0);
    @(negedge clk);
    bus.sram_data_ok = 1'b0;
    #1;
    chk("err_set", 64'(bus.resp_err), 64'h1);
    @(negedge clk); @(negedge clk); #1;
    chk("err_sticky", 64'(bus.resp_err), 64'h1);

    // Ordering: port0, port1, port0, then three responses
    do_reset();
    @(negedge clk);
    bus.req_i = 2'b01; bus.addr_i[0] = 32'h10; bus.sram_addr_ok = 1'b1;
    #1;
    chk("ord_gnt0", 64'(bus.gnt_o), 64'h1);
    @(negedge clk);
    bus.req_i = 2'b10; bus.addr_i[1] = 32'h20;
    #1;
    chk("ord_gnt1", 64'(bus.gnt_o), 64'h2);
    chk("ord_addr1", 64'(bus.sram_addr), 64'h20);
    @(negedge clk);
    bus.req_i = 2'b01; bus.addr_i[0] = 32'h30;
    #1;
    chk("ord_gnt2", 64'(bus.gnt_o), 64'h1);
    @(negedge clk);
    bus.req_i = 2'b00; bus.sram_addr_ok = 1'b0;
    bus.sram_data_ok = 1'b1; bus.sram_rdata = 32'hAAAA0001;
    #1;
    chk("ord_rvalid_a", 64'(bus.rvalid_o), 64'h1);
    chk("ord_rdata_a", 64'(bus.rdata_o), 64'hAAAA0001);
    @(negedge clk);
    bus.sram_rdata = 32'hBBBB0002;
    #1;
    chk("ord_rvalid_b", 64'(bus.rvalid_o), 64'h2);
    chk("ord_rdata_b", 64'(bus.rdata_o), 64'hBBBB0002);
    @(negedge clk);
    bus.sram_rdata = 32'hCCCC0003;
    #1;
    chk("ord_rvalid_c", 64'(bus.rvalid_o), 64'h1);
    chk("ord_rdata_c", 64'(bus.rdata_o), 64'hCCCC0003);
    @(negedge clk);
    bus.sram_data_ok = 1'b0;
    #1;
    chk("ord_done_rvalid", 64'(bus.rvalid_o), 64'h0);
    chk("ord_no_err", 64'(bus.resp_err), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
